// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with a per-register pending-write scoreboard.
// Define REGFILE_SCOREBOARD_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_scoreboard #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter int              NRD      = 2,
  parameter int              SP_INDEX = 2,
  parameter logic [XLEN-1:0] SP_RESET = 32'h0000_03FC,
  localparam int             AW       = $clog2(NREG),
  localparam int             CW       = $clog2(NREG + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  output logic [CW-1:0]       busy_cnt,
  output logic                hazard
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            iss_en, wb_en, cnt_inc, cnt_dec;
  logic [AW-1:0]   ra;

  // Register 0 is hard-wired: issue and writeback to it are dropped here.
  assign iss_en = iss_valid && (iss_addr != '0);
  assign wb_en  = wb_valid && (wb_addr != '0);

  always_comb begin
    busy_d = busy_q;
    if (wb_en)  busy_d[wb_addr]  = 1'b0;
    if (iss_en) busy_d[iss_addr] = 1'b1;
    // Issue wins over writeback on the same address, so no decrement there.
    cnt_inc = iss_en && !busy_q[iss_addr];
    cnt_dec = wb_en && busy_q[wb_addr] && !(iss_en && (iss_addr == wb_addr));
    cnt_d   = cnt_q;
    if (cnt_inc && !cnt_dec)      cnt_d = cnt_q + CW'(1);
    else if (cnt_dec && !cnt_inc) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= (r == SP_INDEX) ? SP_RESET : '0;
      end
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      if (wb_en) regs_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int i = 0; i < NRD; i++) begin
      ra                        = rd_addr[i*AW +: AW];
      rd_data[i*XLEN +: XLEN]   = (ra == '0) ? '0 : regs_q[ra];
      rd_busy[i]                = busy_q[ra];
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
      if (wb_en && (wb_addr == ra)) begin
        rd_data[i*XLEN +: XLEN] = wb_data;
        rd_busy[i]              = iss_en && (iss_addr == ra);
      end
`endif
    end
  end

  assign busy_cnt = cnt_q;
  assign hazard   = |rd_busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: expected read-port snapshots are queued with the stimulus.
module tb_regfile_scoreboard;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;
  localparam int CW   = 6;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic                wb_valid;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic [CW-1:0]       busy_cnt;
  logic                hazard;

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .busy_cnt(busy_cnt), .hazard(hazard)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic [5:0]  cnt;
    logic        haz;
  } rec_t;

  rec_t  exp_q[$];
  rec_t  obs_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic idle();
    iss_valid = 1'b0; iss_addr = '0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic expect_r(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [1:0] b, input logic [5:0] c, input logic h);
    rec_t r;
    r.d0 = d0; r.d1 = d1; r.busy = b; r.cnt = c; r.haz = h;
    exp_q.push_back(r);
    tag_q.push_back(tag);
  endtask

  task automatic sample();
    rec_t r;
    #1;
    r.d0 = rd_data[31:0]; r.d1 = rd_data[63:32]; r.busy = rd_busy; r.cnt = busy_cnt; r.haz = hazard;
    obs_q.push_back(r);
  endtask

  task automatic test_reset();
    rec_t e, o; string t;
    rst_n = 1'b0;
    iss_valid = 1'b1; iss_addr = 5'd6; wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h5555_AAAA;
    cyc(); cyc();
    rst_n = 1'b1; idle();
    for (int k = 0; k < NREG / 2; k++) begin
      rd(5'(2 * k), 5'(2 * k + 1));
      expect_r($sformatf("reset_x%0d", 2 * k), (2 * k == 2) ? 32'h3FC : 32'h0, 32'h0, 2'b00, 6'd0, 1'b0);
      sample();
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL %s: no sample recorded", t); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL %s: got d0=%h d1=%h busy=%b cnt=%0d haz=%b required d0=%h d1=%h busy=%b cnt=%0d haz=%b",
                   t, o.d0, o.d1, o.busy, o.cnt, o.haz, e.d0, e.d1, e.busy, e.cnt, e.haz);
        end
      end
    end
  endtask

  task automatic test_issue_wb();
    rec_t e, o; string t;
    idle(); iss_valid = 1'b1; iss_addr = 5'd5;
    cyc(); idle(); rd(5'd5, 5'd0);
    expect_r("issue_x5", 32'h0, 32'h0, 2'b01, 6'd1, 1'b1); sample();
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    cyc(); idle();
    expect_r("wb_x5", 32'hDEAD_BEEF, 32'h0, 2'b00, 6'd0, 1'b0); sample();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL %s: no sample recorded", t); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL %s: got d0=%h d1=%h busy=%b cnt=%0d haz=%b required d0=%h d1=%h busy=%b cnt=%0d haz=%b",
                   t, o.d0, o.d1, o.busy, o.cnt, o.haz, e.d0, e.d1, e.busy, e.cnt, e.haz);
        end
      end
    end
  endtask

  task automatic test_x0_guard();
    rec_t e, o; string t;
    rd(5'd0, 5'd0);
    iss_valid = 1'b1; iss_addr = 5'd0;
    cyc(); idle();
    expect_r("x0_issue", 32'h0, 32'h0, 2'b00, 6'd0, 1'b0); sample();
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    expect_r("x0_wb_same_cycle", 32'h0, 32'h0, 2'b00, 6'd0, 1'b0); sample();
    cyc(); idle();
    expect_r("x0_wb_after", 32'h0, 32'h0, 2'b00, 6'd0, 1'b0); sample();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL %s: no sample recorded", t); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL %s: got d0=%h d1=%h busy=%b cnt=%0d haz=%b required d0=%h d1=%h busy=%b cnt=%0d haz=%b",
                   t, o.d0, o.d1, o.busy, o.cnt, o.haz, e.d0, e.d1, e.busy, e.cnt, e.haz);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    rec_t e, o; string t;
    iss_valid = 1'b1; iss_addr = 5'd7;
    cyc(); idle(); rd(5'd7, 5'd0);
    expect_r("issue_x7", 32'h0, 32'h0, 2'b01, 6'd1, 1'b1); sample();
    iss_valid = 1'b1; iss_addr = 5'd7; wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
    cyc(); idle();
    expect_r("iss_wb_x7", 32'h1234, 32'h0, 2'b01, 6'd1, 1'b1); sample();
    iss_valid = 1'b1; iss_addr = 5'd3;
    cyc(); idle(); rd(5'd3, 5'd4);
    expect_r("issue_x3", 32'h0, 32'h0, 2'b01, 6'd2, 1'b1); sample();
    iss_valid = 1'b1; iss_addr = 5'd4; wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    cyc(); idle();
    expect_r("iss_x4_wb_x3", 32'h33, 32'h0, 2'b10, 6'd2, 1'b1); sample();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL %s: no sample recorded", t); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL %s: got d0=%h d1=%h busy=%b cnt=%0d haz=%b required d0=%h d1=%h busy=%b cnt=%0d haz=%b",
                   t, o.d0, o.d1, o.busy, o.cnt, o.haz, e.d0, e.d1, e.busy, e.cnt, e.haz);
        end
      end
    end
  endtask

  task automatic test_bypass();
    rec_t e, o; string t;
    iss_valid = 1'b1; iss_addr = 5'd9;
    cyc(); idle(); rd(5'd4, 5'd9);
    expect_r("issue_x9", 32'h0, 32'h0, 2'b11, 6'd3, 1'b1); sample();
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5A5_A5A5;
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
    expect_r("wb_x9_during", 32'h0, 32'hA5A5_A5A5, 2'b01, 6'd3, 1'b1); sample();
`else
    expect_r("wb_x9_during", 32'h0, 32'h0, 2'b11, 6'd3, 1'b1); sample();
`endif
    cyc(); idle();
    expect_r("wb_x9_after", 32'h0, 32'hA5A5_A5A5, 2'b01, 6'd2, 1'b1); sample();
    iss_valid = 1'b1; iss_addr = 5'd4; wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
    expect_r("iss_wb_x4_during", 32'h44, 32'hA5A5_A5A5, 2'b01, 6'd2, 1'b1); sample();
`else
    expect_r("iss_wb_x4_during", 32'h0, 32'hA5A5_A5A5, 2'b01, 6'd2, 1'b1); sample();
`endif
    cyc(); idle();
    expect_r("iss_wb_x4_after", 32'h44, 32'hA5A5_A5A5, 2'b01, 6'd2, 1'b1); sample();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL %s: no sample recorded", t); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL %s: got d0=%h d1=%h busy=%b cnt=%0d haz=%b required d0=%h d1=%h busy=%b cnt=%0d haz=%b",
                   t, o.d0, o.d1, o.busy, o.cnt, o.haz, e.d0, e.d1, e.busy, e.cnt, e.haz);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, o; string t;
    rd(5'd11, 5'd13);
    iss_valid = 1'b1; iss_addr = 5'd11;
    cyc(); expect_r("b2b_iss_x11", 32'h0, 32'h0, 2'b01, 6'd3, 1'b1); sample();
    iss_addr = 5'd12;
    cyc(); expect_r("b2b_iss_x12", 32'h0, 32'h0, 2'b01, 6'd4, 1'b1); sample();
    iss_addr = 5'd13;
    cyc(); expect_r("b2b_iss_x13", 32'h0, 32'h0, 2'b11, 6'd5, 1'b1); sample();
    iss_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd11; wb_data = 32'hB11;
    cyc(); expect_r("b2b_wb_x11", 32'hB11, 32'h0, 2'b10, 6'd4, 1'b1); sample();
    wb_addr = 5'd12; wb_data = 32'hB12;
    cyc(); expect_r("b2b_wb_x12", 32'hB11, 32'h0, 2'b10, 6'd3, 1'b1); sample();
    wb_addr = 5'd13; wb_data = 32'hB13;
    cyc(); idle();
    expect_r("b2b_wb_x13", 32'hB11, 32'hB13, 2'b00, 6'd2, 1'b0); sample();
    rd(5'd12, 5'd7);
    expect_r("b2b_x12_x7", 32'hB12, 32'h1234, 2'b10, 6'd2, 1'b1); sample();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL %s: no sample recorded", t); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL %s: got d0=%h d1=%h busy=%b cnt=%0d haz=%b required d0=%h d1=%h busy=%b cnt=%0d haz=%b",
                   t, o.d0, o.d1, o.busy, o.cnt, o.haz, e.d0, e.d1, e.busy, e.cnt, e.haz);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    rec_t e, o; string t;
    iss_valid = 1'b1; iss_addr = 5'd10;
    cyc(); idle(); rd(5'd10, 5'd7);
    expect_r("mid_three_busy", 32'h0, 32'h1234, 2'b11, 6'd3, 1'b1); sample();
    rst_n = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'h0000_0BAD; iss_valid = 1'b1; iss_addr = 5'd15;
    cyc(); rst_n = 1'b1; idle();
    expect_r("mid_after_x10_x7", 32'h0, 32'h0, 2'b00, 6'd0, 1'b0); sample();
    rd(5'd2, 5'd15);
    expect_r("mid_after_x2_x15", 32'h3FC, 32'h0, 2'b00, 6'd0, 1'b0); sample();
    rd(5'd4, 5'd9);
    expect_r("mid_after_x4_x9", 32'h0, 32'h0, 2'b00, 6'd0, 1'b0); sample();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL %s: no sample recorded", t); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL %s: got d0=%h d1=%h busy=%b cnt=%0d haz=%b required d0=%h d1=%h busy=%b cnt=%0d haz=%b",
                   t, o.d0, o.d1, o.busy, o.cnt, o.haz, e.d0, e.d1, e.busy, e.cnt, e.haz);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    rd(5'd0, 5'd0);
    test_reset();
    test_issue_wb();
    test_x0_guard();
    test_same_cycle();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
